// File: rtl/mc_cu_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes, funcs,
// datapath mux codes and ALU ops, plus the ALU control and legality decode.
package mc_cu_pkg;

  typedef logic [4:0] alu_op_t;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_MULDIV = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam logic [1:0] PCSRC_ALU  = 2'd0;
  localparam logic [1:0] PCSRC_OUT  = 2'd1;
  localparam logic [1:0] PCSRC_JUMP = 2'd2;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_BOFF = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  localparam alu_op_t ALU_ADD  = 5'd0;
  localparam alu_op_t ALU_SUB  = 5'd1;
  localparam alu_op_t ALU_AND  = 5'd2;
  localparam alu_op_t ALU_OR   = 5'd3;
  localparam alu_op_t ALU_XOR  = 5'd4;
  localparam alu_op_t ALU_NOR  = 5'd5;
  localparam alu_op_t ALU_SLT  = 5'd6;
  localparam alu_op_t ALU_SLTU = 5'd7;
  localparam alu_op_t ALU_SLL  = 5'd8;
  localparam alu_op_t ALU_SRL  = 5'd9;
  localparam alu_op_t ALU_SRA  = 5'd10;
  localparam alu_op_t ALU_LUI  = 5'd11;
  localparam alu_op_t ALU_MUL  = 5'd12;
  localparam alu_op_t ALU_MULU = 5'd13;
  localparam alu_op_t ALU_DIV  = 5'd14;
  localparam alu_op_t ALU_DIVU = 5'd15;
  localparam alu_op_t ALU_MFHI = 5'd16;
  localparam alu_op_t ALU_MFLO = 5'd17;
  localparam alu_op_t ALU_ADDU = 5'd18;
  localparam alu_op_t ALU_SUBU = 5'd19;

  function automatic logic is_muldiv_fn(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

  function automatic alu_op_t alu_ctrl(input logic [5:0] op, input logic [5:0] fn);
    alu_op_t r;
    r = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD:   r = ALU_ADD;
          FN_ADDU:  r = ALU_ADDU;
          FN_SUB:   r = ALU_SUB;
          FN_SUBU:  r = ALU_SUBU;
          FN_AND:   r = ALU_AND;
          FN_OR:    r = ALU_OR;
          FN_XOR:   r = ALU_XOR;
          FN_NOR:   r = ALU_NOR;
          FN_SLT:   r = ALU_SLT;
          FN_SLTU:  r = ALU_SLTU;
          FN_SLL:   r = ALU_SLL;
          FN_SRL:   r = ALU_SRL;
          FN_SRA:   r = ALU_SRA;
          FN_MFHI:  r = ALU_MFHI;
          FN_MFLO:  r = ALU_MFLO;
          FN_MULT:  r = ALU_MUL;
          FN_MULTU: r = ALU_MULU;
          FN_DIV:   r = ALU_DIV;
          FN_DIVU:  r = ALU_DIVU;
          default:  r = ALU_ADD;
        endcase
      end
      OP_ADDI:  r = ALU_ADD;
      OP_ADDIU: r = ALU_ADDU;
      OP_SLTI:  r = ALU_SLT;
      OP_SLTIU: r = ALU_SLTU;
      OP_ANDI:  r = ALU_AND;
      OP_ORI:   r = ALU_OR;
      OP_XORI:  r = ALU_XOR;
      OP_LUI:   r = ALU_LUI;
      OP_BEQ, OP_BNE: r = ALU_SUB;
      default:  r = ALU_ADD;
    endcase
    return r;
  endfunction

  function automatic logic op_legal(input logic [5:0] op, input logic [5:0] fn,
                                    input logic muldiv_en);
    logic r;
    r = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_MFHI, FN_MFLO: r = 1'b1;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: r = muldiv_en;
          default: r = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_cu_muldiv_timer.sv
// MULDIV stall timer: loads N-1 on entry (N picked by mul/div), counts down,
// flags done at zero so the last MULDIV cycle can fire HiLoWrite.
module mc_cu_muldiv_timer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_sel_div,
  input  logic i_dec,
  output logic o_done
);
  localparam int MAX_N = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW    = $clog2(MAX_N) + 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_sel_div ? DIV_LOAD : MUL_LOAD;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_done = (r_count == '0);
endmodule

// File: rtl/mc_cu.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB/MULDIV and
// drives the shared-datapath mux selects and write enables.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4 -> PC and IR on mem_ready
// DECODE | branch target -> ALUOut; jumps complete here
// EXEC   | ALU operation / address calc / branch resolution
// MEM    | data access at ALUOut, held until mem_ready
// WB     | register file write
// MULDIV | multi-cycle multiply/divide stall, HiLoWrite on last cycle
module mc_cu
  import mc_cu_pkg::*;
#(
  parameter int MUL_CYCLES    = 4,
  parameter int DIV_CYCLES    = 32,
  parameter bit ENABLE_MULDIV = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] OPcode,
  input  logic [5:0] Func,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       ALUSrc_A,
  output logic [1:0] ALUSrc_B,
  output logic [4:0] ALU_Control,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       HiLoWrite,
  output logic       busy,
  output logic       illegal
);
  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic       w_rtype, w_is_lw, w_is_sw, w_is_beq, w_is_bne, w_is_j, w_is_jal;
  logic       w_legal, w_muldiv, w_sel_div, w_tmr_load, w_tmr_done;

  assign w_rtype   = (OPcode == OP_RTYPE);
  assign w_is_lw   = (OPcode == OP_LW);
  assign w_is_sw   = (OPcode == OP_SW);
  assign w_is_beq  = (OPcode == OP_BEQ);
  assign w_is_bne  = (OPcode == OP_BNE);
  assign w_is_j    = (OPcode == OP_J);
  assign w_is_jal  = (OPcode == OP_JAL);
  assign w_legal   = op_legal(OPcode, Func, ENABLE_MULDIV);
  assign w_muldiv  = w_rtype && is_muldiv_fn(Func) && ENABLE_MULDIV;
  assign w_sel_div = (Func == FN_DIV) || (Func == FN_DIVU);

  assign w_tmr_load = (r_state == ST_DECODE) && w_legal && w_muldiv;

  mc_cu_muldiv_timer #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_tmr_load),
    .i_sel_div(w_sel_div),
    .i_dec    (r_state == ST_MULDIV),
    .o_done   (w_tmr_done)
  );

  always_comb begin
    w_next_state = ST_FETCH;
    case (r_state)
      ST_FETCH:  w_next_state = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (!w_legal || w_is_j || w_is_jal) w_next_state = ST_FETCH;
        else if (w_muldiv)                  w_next_state = ST_MULDIV;
        else                                w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        if (w_is_beq || w_is_bne)     w_next_state = ST_FETCH;
        else if (w_is_lw || w_is_sw)  w_next_state = ST_MEM;
        else                          w_next_state = ST_WB;
      end
      ST_MEM: begin
        if (!mem_ready)   w_next_state = ST_MEM;
        else if (w_is_lw) w_next_state = ST_WB;
        else              w_next_state = ST_FETCH;
      end
      ST_WB:     w_next_state = ST_FETCH;
      ST_MULDIV: w_next_state = w_tmr_done ? ST_FETCH : ST_MULDIV;
      default:   w_next_state = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_FETCH;
    else          r_state <= w_next_state;
  end

  // Everything defaults low; while reset_n is low nothing is asserted at all.
  always_comb begin
    PCWrite     = 1'b0;
    PCSrc       = PCSRC_ALU;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrc_A    = 1'b0;
    ALUSrc_B    = SRCB_RT;
    ALU_Control = ALU_ADD;
    RegDst      = DST_RT;
    MemtoReg    = M2R_ALU;
    RegWrite    = 1'b0;
    HiLoWrite   = 1'b0;
    busy        = 1'b0;
    illegal     = 1'b0;
    if (reset_n) begin
      case (r_state)
        ST_FETCH: begin
          MemRead  = 1'b1;
          ALUSrc_B = SRCB_FOUR;
          IRWrite  = mem_ready;
          PCWrite  = mem_ready;
        end
        ST_DECODE: begin
          busy     = 1'b1;
          ALUSrc_B = SRCB_BOFF;
          if (!w_legal) begin
            illegal = 1'b1;
          end else if (w_is_j || w_is_jal) begin
            PCWrite = 1'b1;
            PCSrc   = PCSRC_JUMP;
            if (w_is_jal) begin
              RegWrite = 1'b1;
              RegDst   = DST_RA;
              MemtoReg = M2R_PC;
            end
          end
        end
        ST_EXEC: begin
          busy     = 1'b1;
          ALUSrc_A = 1'b1;
          ALUSrc_B = (w_rtype || w_is_beq || w_is_bne) ? SRCB_RT : SRCB_IMM;
          ALU_Control = alu_ctrl(OPcode, Func);
          if (w_is_beq || w_is_bne) begin
            ALU_Control = ALU_SUB;
            PCSrc       = PCSRC_OUT;
            PCWrite     = w_is_beq ? Zero : ~Zero;
          end
        end
        ST_MEM: begin
          busy     = 1'b1;
          IorD     = 1'b1;
          MemRead  = w_is_lw;
          MemWrite = w_is_sw;
        end
        ST_WB: begin
          busy     = 1'b1;
          RegWrite = 1'b1;
          RegDst   = w_rtype ? DST_RD : DST_RT;
          MemtoReg = w_is_lw ? M2R_MDR : M2R_ALU;
        end
        ST_MULDIV: begin
          busy        = 1'b1;
          ALUSrc_A    = 1'b1;
          ALU_Control = alu_ctrl(OPcode, Func);
          HiLoWrite   = w_tmr_done;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_cu.sv
// Directed bench for mc_cu: stimulus pushes the expected per-cycle control word
// into a scoreboard queue, a monitor on the falling edge pops and compares.
module tb_mc_cu;
  import mc_cu_pkg::*;

  logic clk = 1'b1;
  logic reset_n;
  logic [5:0] OPcode, Func;
  logic Zero, mem_ready;
  logic PCWrite, IorD, MemRead, MemWrite, IRWrite, ALUSrc_A, RegWrite, HiLoWrite, busy, illegal;
  logic [1:0] PCSrc, ALUSrc_B, RegDst, MemtoReg;
  logic [4:0] ALU_Control;

  always #5 clk = ~clk;

  mc_cu #(.MUL_CYCLES(1), .DIV_CYCLES(32), .ENABLE_MULDIV(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .OPcode(OPcode), .Func(Func), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .ALUSrc_A(ALUSrc_A),
    .ALUSrc_B(ALUSrc_B), .ALU_Control(ALU_Control), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .HiLoWrite(HiLoWrite),
    .busy(busy), .illegal(illegal)
  );

  typedef struct {
    string       nm;
    logic [22:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [22:0] w_act;
  assign w_act = {PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite, ALUSrc_A, ALUSrc_B,
                  ALU_Control, RegDst, MemtoReg, RegWrite, HiLoWrite, busy, illegal};

  function automatic logic [22:0] cw(
    input logic pcw, input logic [1:0] pcsrc, input logic iord, input logic mrd,
    input logic mwr, input logic irw, input logic asa, input logic [1:0] asb,
    input logic [4:0] alu, input logic [1:0] rdst, input logic [1:0] m2r,
    input logic rw, input logic hlw, input logic bsy, input logic ill);
    return {pcw, pcsrc, iord, mrd, mwr, irw, asa, asb, alu, rdst, m2r, rw, hlw, bsy, ill};
  endfunction

  function automatic logic [22:0] e_fetch(input logic mr);
    return cw(mr, 2'd0, 0, 1, 0, mr, 0, 2'd1, ALU_ADD, 2'd0, 2'd0, 0, 0, 0, 0);
  endfunction

  function automatic logic [22:0] e_dec();
    return cw(0, 2'd0, 0, 0, 0, 0, 0, 2'd3, ALU_ADD, 2'd0, 2'd0, 0, 0, 1, 0);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if (w_act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %06h expected %06h (t=%0t)", e.nm, w_act, e.exp, $time);
      end
    end
  end

  task automatic cyc(input string nm, input logic rn, input logic mr, input logic z,
                     input logic [22:0] exp);
    exp_t e;
    reset_n   = rn;
    mem_ready = mr;
    Zero      = z;
    e.nm  = nm;
    e.exp = exp;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic start(input string nm, input logic [5:0] op, input logic [5:0] fn);
    OPcode = op;
    Func   = fn;
    cyc({nm, "_fetch"}, 1, 1, 0, e_fetch(1'b1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d expected 0", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; OPcode = 6'd0; Func = 6'd0; Zero = 1'b0; mem_ready = 1'b0;

    cyc("rst0", 0, 0, 0, 23'd0);
    cyc("rst1", 0, 1, 0, 23'd0);

    // ADD $3,$1,$2: 4 cycles, register write only in WB
    start("add", 6'b000000, 6'b100000);
    cyc("add_dec", 1, 1, 0, e_dec());
    cyc("add_exec", 1, 1, 0, cw(0, 2'd0, 0, 0, 0, 0, 1, 2'd0, ALU_ADD, 2'd0, 2'd0, 0, 0, 1, 0));
    cyc("add_wb", 1, 1, 0, cw(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 5'd0, 2'd1, 2'd0, 1, 0, 1, 0));

    // LW with 2 fetch waits and 3 memory waits: 10 cycles
    OPcode = 6'b100011; Func = 6'b000000;
    cyc("lw_fetch_w0", 1, 0, 0, e_fetch(1'b0));
    cyc("lw_fetch_w1", 1, 0, 0, e_fetch(1'b0));
    cyc("lw_fetch", 1, 1, 0, e_fetch(1'b1));
    cyc("lw_dec", 1, 1, 0, e_dec());
    cyc("lw_exec", 1, 1, 0, cw(0, 2'd0, 0, 0, 0, 0, 1, 2'd2, ALU_ADD, 2'd0, 2'd0, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      cyc("lw_mem_wait", 1, 0, 0, cw(0, 2'd0, 1, 1, 0, 0, 0, 2'd0, 5'd0, 2'd0, 2'd0, 0, 0, 1, 0));
    cyc("lw_mem", 1, 1, 0, cw(0, 2'd0, 1, 1, 0, 0, 0, 2'd0, 5'd0, 2'd0, 2'd0, 0, 0, 1, 0));
    cyc("lw_wb", 1, 1, 0, cw(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 5'd0, 2'd0, 2'd1, 1, 0, 1, 0));

    // SW with one memory wait, returns to FETCH straight from MEM
    start("sw", 6'b101011, 6'b000000);
    cyc("sw_dec", 1, 1, 0, e_dec());
    cyc("sw_exec", 1, 1, 0, cw(0, 2'd0, 0, 0, 0, 0, 1, 2'd2, ALU_ADD, 2'd0, 2'd0, 0, 0, 1, 0));
    cyc("sw_mem_wait", 1, 0, 0, cw(0, 2'd0, 1, 0, 1, 0, 0, 2'd0, 5'd0, 2'd0, 2'd0, 0, 0, 1, 0));
    cyc("sw_mem", 1, 1, 0, cw(0, 2'd0, 1, 0, 1, 0, 0, 2'd0, 5'd0, 2'd0, 2'd0, 0, 0, 1, 0));

    // Branches: 3 cycles each, PCWrite follows Zero/~Zero in EXEC
    start("beq_z1", 6'b000100, 6'b000000);
    cyc("beq_z1_dec", 1, 1, 1, e_dec());
    cyc("beq_z1_exec", 1, 1, 1, cw(1, 2'd1, 0, 0, 0, 0, 1, 2'd0, ALU_SUB, 2'd0, 2'd0, 0, 0, 1, 0));
    start("beq_z0", 6'b000100, 6'b000000);
    cyc("beq_z0_dec", 1, 1, 0, e_dec());
    cyc("beq_z0_exec", 1, 1, 0, cw(0, 2'd1, 0, 0, 0, 0, 1, 2'd0, ALU_SUB, 2'd0, 2'd0, 0, 0, 1, 0));
    start("bne_z1", 6'b000101, 6'b000000);
    cyc("bne_z1_dec", 1, 1, 1, e_dec());
    cyc("bne_z1_exec", 1, 1, 1, cw(0, 2'd1, 0, 0, 0, 0, 1, 2'd0, ALU_SUB, 2'd0, 2'd0, 0, 0, 1, 0));
    start("bne_z0", 6'b000101, 6'b000000);
    cyc("bne_z0_dec", 1, 1, 0, e_dec());
    cyc("bne_z0_exec", 1, 1, 0, cw(1, 2'd1, 0, 0, 0, 0, 1, 2'd0, ALU_SUB, 2'd0, 2'd0, 0, 0, 1, 0));

    // J and JAL complete in DECODE
    start("j", 6'b000010, 6'b000000);
    cyc("j_dec", 1, 1, 0, cw(1, 2'd2, 0, 0, 0, 0, 0, 2'd3, ALU_ADD, 2'd0, 2'd0, 0, 0, 1, 0));
    start("jal", 6'b000011, 6'b000000);
    cyc("jal_dec", 1, 1, 0, cw(1, 2'd2, 0, 0, 0, 0, 0, 2'd3, ALU_ADD, 2'd2, 2'd2, 1, 0, 1, 0));

    // ADDIU: immediate operand, write to rt
    start("addiu", 6'b001001, 6'b000000);
    cyc("addiu_dec", 1, 1, 0, e_dec());
    cyc("addiu_exec", 1, 1, 0, cw(0, 2'd0, 0, 0, 0, 0, 1, 2'd2, ALU_ADDU, 2'd0, 2'd0, 0, 0, 1, 0));
    cyc("addiu_wb", 1, 1, 0, cw(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 5'd0, 2'd0, 2'd0, 1, 0, 1, 0));

    // MULT with MUL_CYCLES=1: a single MULDIV cycle carrying HiLoWrite
    start("mult", 6'b000000, 6'b011000);
    cyc("mult_dec", 1, 1, 0, e_dec());
    cyc("mult_md", 1, 1, 0, cw(0, 2'd0, 0, 0, 0, 0, 1, 2'd0, ALU_MUL, 2'd0, 2'd0, 0, 1, 1, 0));

    // DIV with DIV_CYCLES=32: HiLoWrite only on the 32nd MULDIV cycle
    start("div", 6'b000000, 6'b011010);
    cyc("div_dec", 1, 1, 0, e_dec());
    for (int i = 0; i < 31; i++)
      cyc("div_md", 1, 1, 0, cw(0, 2'd0, 0, 0, 0, 0, 1, 2'd0, ALU_DIV, 2'd0, 2'd0, 0, 0, 1, 0));
    cyc("div_md_last", 1, 1, 0, cw(0, 2'd0, 0, 0, 0, 0, 1, 2'd0, ALU_DIV, 2'd0, 2'd0, 0, 1, 1, 0));

    // Unsupported opcode: one illegal pulse in DECODE, then FETCH
    start("ill", 6'b111111, 6'b000000);
    cyc("ill_dec", 1, 1, 0, cw(0, 2'd0, 0, 0, 0, 0, 0, 2'd3, ALU_ADD, 2'd0, 2'd0, 0, 0, 1, 1));

    // DIVU aborted by reset in MULDIV cycle 5
    start("abort", 6'b000000, 6'b011011);
    cyc("abort_dec", 1, 1, 0, e_dec());
    for (int i = 0; i < 4; i++)
      cyc("abort_md", 1, 1, 0, cw(0, 2'd0, 0, 0, 0, 0, 1, 2'd0, ALU_DIVU, 2'd0, 2'd0, 0, 0, 1, 0));
    cyc("abort_rst", 0, 1, 0, 23'd0);
    OPcode = 6'b000000; Func = 6'b100010;
    cyc("post_rst_fetch_w", 1, 0, 0, e_fetch(1'b0));
    cyc("post_rst_fetch", 1, 1, 0, e_fetch(1'b1));
    cyc("sub_dec", 1, 1, 0, e_dec());
    cyc("sub_exec", 1, 1, 0, cw(0, 2'd0, 0, 0, 0, 0, 1, 2'd0, ALU_SUB, 2'd0, 2'd0, 0, 0, 1, 0));
    cyc("sub_wb", 1, 1, 0, cw(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 5'd0, 2'd1, 2'd0, 1, 0, 1, 0));
    cyc("idle_fetch", 1, 0, 0, e_fetch(1'b0));

    @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: queue depth %0d expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
